// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to downstream pixel generators.
// The master modport drives the bundle. The slave modport samples it.
interface vga_timing_gen_if;
  logic       pix_tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] x;
  logic [8:0] y;
  logic       display_on;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;

  modport master (
    output pix_tick, h_cnt, v_cnt, x, y, display_on,
           hsync, vsync, line_start, frame_start
  );

  modport slave (
    input  pix_tick, h_cnt, v_cnt, x, y, display_on,
           hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A clock divider produces the pixel enable. Horizontal and vertical counters
// run from that enable. The registered decodes (sync pulses, display enable,
// visible coordinates) are computed from next-state counter values, so they
// change on the same edge as h_cnt/v_cnt.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]       V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]       HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]       HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]       VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]       VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic             HS_ACT   = (HSYNC_POL != 0);
  localparam logic             VS_ACT   = (VSYNC_POL != 0);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             pix_tick;
  logic             h_wrap;
  logic             v_wrap;
  logic             on_nxt;

  logic [9:0]       x_p1;
  logic [8:0]       y_p1;
  logic             on_p1;
  logic             hsync_p1;
  logic             vsync_p1;

  // Flag parameter sets whose totals overflow the 10-bit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (H_TOTAL <= 1024 && V_TOTAL <= 1024)
        else $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
  end

  // Pixel clock divider: count 0..CLK_DIV-1 and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // Tick, wrap detection and next-state counters. Reset masks the tick,
  // so no wrap pulse can escape while rst is high.
  always_comb begin
    pix_tick = (div_cnt == DIV_LAST) && !rst;
    h_wrap   = pix_tick && (h_cnt == H_LAST);
    v_wrap   = h_wrap && (v_cnt == V_LAST);
    h_nxt    = h_cnt;
    v_nxt    = v_cnt;
    if (pix_tick) begin
      h_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap) begin
        v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
      end
    end
    on_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Registered decodes from next-state counters, aligned with h_cnt/v_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_p1     <= '0;
      y_p1     <= '0;
      on_p1    <= 1'b1;
      hsync_p1 <= ~HS_ACT;
      vsync_p1 <= ~VS_ACT;
    end else begin
      x_p1     <= on_nxt ? h_nxt : 10'd0;
      y_p1     <= on_nxt ? v_nxt[8:0] : 9'd0;
      on_p1    <= on_nxt;
      hsync_p1 <= (h_nxt >= HS_START && h_nxt < HS_END) ? HS_ACT : ~HS_ACT;
      vsync_p1 <= (v_nxt >= VS_START && v_nxt < VS_END) ? VS_ACT : ~VS_ACT;
    end
  end

  assign vga.pix_tick    = pix_tick;
  assign vga.h_cnt       = h_cnt;
  assign vga.v_cnt       = v_cnt;
  assign vga.x           = x_p1;
  assign vga.y           = y_p1;
  assign vga.display_on  = on_p1;
  assign vga.hsync       = hsync_p1;
  assign vga.vsync       = vsync_p1;
  assign vga.line_start  = h_wrap;
  assign vga.frame_start = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen.
// dut_a: default timing, CLK_DIV=2. It exercises reset release, the divider and
//        a reset while the divider is mid-count.
// dut_b: default timing, CLK_DIV=1. It runs one full line.
// dut_c: small timing with CLK_DIV=1 and inverted sync polarity.
//        It runs a full frame and then a reset while both syncs are active.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  logic rst_c;

  vga_timing_gen_if vif_a();
  vga_timing_gen_if vif_b();
  vga_timing_gen_if vif_c();

  vga_timing_gen #(.CLK_DIV(2)) dut_a (.clk(clk), .rst(rst_a), .vga(vif_a));
  vga_timing_gen #(.CLK_DIV(1)) dut_b (.clk(clk), .rst(rst_b), .vga(vif_b));
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(1)
  ) dut_c (.clk(clk), .rst(rst_c), .vga(vif_c));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst;
    logic tick;
    int   h;
    int   x;
    logic on;
    logic hs;
    logic vs;
    logic ls;
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    int h;
    int v;
    int hs_cnt;
    int vs_cnt;
    int ls_cnt;
    int fs_cnt;

    // Each row gives: rst applied at the negedge, then the outputs expected
    // in that same cycle.
    vecs[0] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1, 1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 2, 2, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 2, 2, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (3) @(negedge clk);

    // dut_a: reset release and divider pattern, table-driven.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst_a = vecs[i].rst;
      #1;
      chk($sformatf("a_tick[%0d]", i), vif_a.pix_tick, vecs[i].tick);
      chk($sformatf("a_h[%0d]", i), vif_a.h_cnt, vecs[i].h);
      chk($sformatf("a_v[%0d]", i), vif_a.v_cnt, 0);
      chk($sformatf("a_x[%0d]", i), vif_a.x, vecs[i].x);
      chk($sformatf("a_y[%0d]", i), vif_a.y, 0);
      chk($sformatf("a_on[%0d]", i), vif_a.display_on, vecs[i].on);
      chk($sformatf("a_hs[%0d]", i), vif_a.hsync, vecs[i].hs);
      chk($sformatf("a_vs[%0d]", i), vif_a.vsync, vecs[i].vs);
      chk($sformatf("a_ls[%0d]", i), vif_a.line_start, vecs[i].ls);
      chk($sformatf("a_fs[%0d]", i), vif_a.frame_start, 0);
    end

    // dut_b: one full line at CLK_DIV=1, then the first pixel of line 1.
    hs_cnt = 0;
    ls_cnt = 0;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    for (int k = 0; k <= 800; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      h = k % 800;
      v = k / 800;
      chk("b_tick", vif_b.pix_tick, 1);
      chk("b_h", vif_b.h_cnt, h);
      chk("b_v", vif_b.v_cnt, v);
      chk("b_hsync", vif_b.hsync, (h >= 656 && h < 752) ? 0 : 1);
      chk("b_vsync", vif_b.vsync, 1);
      chk("b_on", vif_b.display_on, (h < 640) ? 1 : 0);
      chk("b_x", vif_b.x, (h < 640) ? h : 0);
      chk("b_y", vif_b.y, (h < 640) ? v : 0);
      chk("b_line_start", vif_b.line_start, (h == 799) ? 1 : 0);
      chk("b_frame_start", vif_b.frame_start, 0);
      if (k < 800 && vif_b.hsync === 1'b0) hs_cnt++;
      if (vif_b.line_start === 1'b1) ls_cnt++;
    end
    chk("b_hsync_width", hs_cnt, 96);
    chk("b_line_start_count", ls_cnt, 1);

    // dut_c: 15 x 10 raster with active-high syncs. It runs one full frame
    // into the next one, up to (h=11, v=7), where both syncs are active.
    hs_cnt = 0;
    vs_cnt = 0;
    fs_cnt = 0;
    @(negedge clk);
    rst_c = 1'b0;
    #1;
    for (int k = 0; k <= 266; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      h = k % 15;
      v = (k / 15) % 10;
      chk("c_tick", vif_c.pix_tick, 1);
      chk("c_h", vif_c.h_cnt, h);
      chk("c_v", vif_c.v_cnt, v);
      chk("c_hsync", vif_c.hsync, (h >= 10 && h < 13) ? 1 : 0);
      chk("c_vsync", vif_c.vsync, (v >= 7 && v < 9) ? 1 : 0);
      chk("c_on", vif_c.display_on, (h < 8 && v < 6) ? 1 : 0);
      chk("c_x", vif_c.x, (h < 8 && v < 6) ? h : 0);
      chk("c_y", vif_c.y, (h < 8 && v < 6) ? v : 0);
      chk("c_line_start", vif_c.line_start, (h == 14) ? 1 : 0);
      chk("c_frame_start", vif_c.frame_start, (h == 14 && v == 9) ? 1 : 0);
      if (k < 150) begin
        if (vif_c.hsync === 1'b1) hs_cnt++;
        if (vif_c.vsync === 1'b1) vs_cnt++;
        if (vif_c.frame_start === 1'b1) fs_cnt++;
      end
    end
    chk("c_hsync_ticks", hs_cnt, 30);
    chk("c_vsync_ticks", vs_cnt, 30);
    chk("c_frame_start_count", fs_cnt, 1);

    // A one-cycle reset at (11,7) masks the tick and any pulse in that cycle.
    rst_c = 1'b1;
    #1;
    chk("c_rst_tick", vif_c.pix_tick, 0);
    chk("c_rst_ls", vif_c.line_start, 0);
    chk("c_rst_fs", vif_c.frame_start, 0);
    chk("c_rst_hold_h", vif_c.h_cnt, 11);
    @(negedge clk);
    rst_c = 1'b0;
    #1;
    chk("c_post_h", vif_c.h_cnt, 0);
    chk("c_post_v", vif_c.v_cnt, 0);
    chk("c_post_x", vif_c.x, 0);
    chk("c_post_y", vif_c.y, 0);
    chk("c_post_on", vif_c.display_on, 1);
    chk("c_post_hsync", vif_c.hsync, 0);
    chk("c_post_vsync", vif_c.vsync, 0);
    chk("c_post_ls", vif_c.line_start, 0);
    chk("c_post_fs", vif_c.frame_start, 0);
    chk("c_post_tick", vif_c.pix_tick, 1);
    @(negedge clk);
    #1;
    chk("c_resume_h", vif_c.h_cnt, 1);
    chk("c_resume_v", vif_c.v_cnt, 0);
    chk("c_resume_x", vif_c.x, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
